// File: rtl/ns_counter.sv
// ----------------------------------------------------------------------------
// ns_counter -- modulo-N up/down counter gated by a two-state IDLE/RUN FSM.
//
// The FSM is entered with start and left with stop; stop wins if both are
// high. While in RUN and with en high, the count steps once per clock in the
// direction given by up, wrapping inside 0..MODULUS-1. tc is high for the one
// cycle in which count holds a value produced by a wrap (or by a bounce in
// ping-pong mode). A load writes load_val, clamped to MODULUS-1, in any state
// and takes priority over stepping. Reset has priority over everything.
//
// Parameters:
//   WIDTH    count register width in bits (2..16)
//   MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   start     in   request to enter RUN
//   stop      in   request to return to IDLE
//   en        in   count enable while in RUN
//   up        in   direction, 1 = increment, 0 = decrement
//   load      in   synchronous parallel load strobe
//   load_val  in   [WIDTH-1:0] value for load
//   count     out  [WIDTH-1:0] registered count
//   tc        out  registered terminal-count pulse
//   busy      out  high while the FSM is in RUN
//
// Build option:
//   NS_COUNTER_BOUNCE_EN  when defined, the counter runs in ping-pong mode:
//   an internal direction register (loaded from up on start or load) turns
//   the count around at each end of the range instead of wrapping, and tc
//   pulses in the cycle count sits on the end value where it turned.
// ----------------------------------------------------------------------------
module ns_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_M1  = WIDTH'(MODULUS - 2);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             tc_reg;
    logic             tc_next;
    logic             step;

`ifdef NS_COUNTER_BOUNCE_EN
    logic dir_reg;
    logic dir_next;
`endif

    // Step uses the current state, so the start cycle itself never steps
    // and the stop cycle still does.
    assign step = (state_reg == RUN) && en && !load;

    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
`ifdef NS_COUNTER_BOUNCE_EN
        dir_next   = dir_reg;
`endif
        if (load) begin
            // Compare against MAX_VAL instead of MODULUS so the comparison
            // stays WIDTH bits wide even when MODULUS == 2**WIDTH.
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
`ifdef NS_COUNTER_BOUNCE_EN
            if (dir_reg) begin
                if (count_reg >= MAX_VAL) begin
                    // Only reachable right after a load/start put us at the
                    // top going up: turn around immediately.
                    count_next = MAX_M1;
                    dir_next   = 1'b0;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_reg + ONE;
                    if (count_reg == MAX_M1) begin
                        dir_next = 1'b0;
                        tc_next  = 1'b1;
                    end
                end
            end else begin
                if (count_reg == ZERO) begin
                    count_next = ONE;
                    dir_next   = 1'b1;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_reg - ONE;
                    if (count_reg == ONE) begin
                        dir_next = 1'b1;
                        tc_next  = 1'b1;
                    end
                end
            end
`else
            if (up) begin
                if (count_reg >= MAX_VAL) begin
                    count_next = ZERO;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_reg + ONE;
                end
            end else begin
                if (count_reg == ZERO) begin
                    count_next = MAX_VAL;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count_reg - ONE;
                end
            end
`endif
        end
`ifdef NS_COUNTER_BOUNCE_EN
        // A fresh start or load re-seeds the direction from the up input.
        if (load || start) begin
            dir_next = up;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= ZERO;
            tc_reg    <= 1'b0;
`ifdef NS_COUNTER_BOUNCE_EN
            dir_reg   <= 1'b1;
`endif
        end else begin
            if (stop) begin
                state_reg <= IDLE;
            end else if (start) begin
                state_reg <= RUN;
            end
            count_reg <= count_next;
            tc_reg    <= tc_next;
`ifdef NS_COUNTER_BOUNCE_EN
            dir_reg   <= dir_next;
`endif
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign busy  = (state_reg == RUN);

endmodule

// File: tb/tb_ns_counter.sv
// ----------------------------------------------------------------------------
// tb_ns_counter -- directed self-checking bench for ns_counter.
// Two instances share all inputs: d16 (WIDTH=4, MODULUS=16) and d10
// (WIDTH=4, MODULUS=10). With NS_COUNTER_BOUNCE_EN defined a third instance
// (WIDTH=2, MODULUS=4) exercises ping-pong mode and the wrap tests are skipped.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ns_counter;

    logic       clk = 1'b0;
    logic       reset, start, stop, en, up, load;
    logic [3:0] load_val;
    logic [3:0] c16, c10;
    logic       tc16, tc10, b16, b10;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ns_counter #(.WIDTH(4), .MODULUS(16)) d16 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(c16), .tc(tc16), .busy(b16));

    ns_counter #(.WIDTH(4), .MODULUS(10)) d10 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(c10), .tc(tc10), .busy(b10));

`ifdef NS_COUNTER_BOUNCE_EN
    logic [1:0] lv_b, cb;
    logic       tcb, bb;
    assign lv_b = load_val[1:0];
    ns_counter #(.WIDTH(2), .MODULUS(4)) db (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .up(up),
        .load(load), .load_val(lv_b), .count(cb), .tc(tcb), .busy(bb));
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; en = 1'b1; up = 1'b1;
        tick(); tick();
        n_cmp++; if (c16 !== 4'd0)  begin n_bad++; $display("FAIL reset_c16 got %0d want 0", c16); end
        n_cmp++; if (c10 !== 4'd0)  begin n_bad++; $display("FAIL reset_c10 got %0d want 0", c10); end
        n_cmp++; if (tc16 !== 1'b0) begin n_bad++; $display("FAIL reset_tc16 got %b want 0", tc16); end
        n_cmp++; if (b16 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b want 0", b16); end
        $display("reset: c16=%0d c10=%0d tc=%b busy=%b", c16, c10, tc16, b16);
        reset = 1'b0; start = 1'b0; en = 1'b0;
        tick();
        n_cmp++; if (c16 !== 4'd0 || b16 !== 1'b0) begin n_bad++; $display("FAIL idle_hold got c=%0d busy=%b want c=0 busy=0", c16, b16); end
    endtask

    // Up counting and wrap on both moduli.
    task automatic test_up_wrap();
        start = 1'b1; up = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (b16 !== 1'b1 || c16 !== 4'd0) begin n_bad++; $display("FAIL start_run got busy=%b c=%0d want busy=1 c=0", b16, c16); end
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            $display("up step %0d: c16=%0d tc16=%b c10=%0d tc10=%b", i, c16, tc16, c10, tc10);
            n_cmp++; if (c16 !== 4'(i % 16)) begin n_bad++; $display("FAIL up16_count step %0d got %0d want %0d", i, c16, i % 16); end
            n_cmp++; if (tc16 !== (i == 16)) begin n_bad++; $display("FAIL up16_tc step %0d got %b want %b", i, tc16, i == 16); end
            n_cmp++; if (c10 !== 4'(i % 10)) begin n_bad++; $display("FAIL up10_count step %0d got %0d want %0d", i, c10, i % 10); end
            n_cmp++; if (tc10 !== (i == 10)) begin n_bad++; $display("FAIL up10_tc step %0d got %b want %b", i, tc10, i == 10); end
        end
        en = 1'b0;
        tick();
        n_cmp++; if (c16 !== 4'd0 || c10 !== 4'd6 || tc16 !== 1'b0) begin n_bad++; $display("FAIL en_hold got c16=%0d c10=%0d tc=%b want 0 6 0", c16, c10, tc16); end
    endtask

    // Down wrap from 0, then an ordinary decrement.
    task automatic test_down_wrap();
        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        $display("down wrap: c16=%0d tc16=%b c10=%0d tc10=%b", c16, tc16, c10, tc10);
        n_cmp++; if (c10 !== 4'd9 || tc10 !== 1'b1)  begin n_bad++; $display("FAIL down10_wrap got c=%0d tc=%b want 9 1", c10, tc10); end
        n_cmp++; if (c16 !== 4'd15 || tc16 !== 1'b1) begin n_bad++; $display("FAIL down16_wrap got c=%0d tc=%b want 15 1", c16, tc16); end
        tick();
        $display("down step: c16=%0d tc16=%b c10=%0d tc10=%b", c16, tc16, c10, tc10);
        n_cmp++; if (c10 !== 4'd8 || tc10 !== 1'b0)  begin n_bad++; $display("FAIL down10_step got c=%0d tc=%b want 8 0", c10, tc10); end
        n_cmp++; if (c16 !== 4'd14 || tc16 !== 1'b0) begin n_bad++; $display("FAIL down16_step got c=%0d tc=%b want 14 0", c16, tc16); end
        en = 1'b0; up = 1'b1;
    endtask

    // Clamped load in IDLE, no stepping in IDLE, load beating step in RUN.
    task automatic test_load_clamp();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (b16 !== 1'b0) begin n_bad++; $display("FAIL stop_idle got busy=%b want 0", b16); end
        load = 1'b1; load_val = 4'd12; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0;
        $display("load 12: c16=%0d c10=%0d tc10=%b busy=%b", c16, c10, tc10, b10);
        n_cmp++; if (c10 !== 4'd9)  begin n_bad++; $display("FAIL load10_clamp got %0d want 9", c10); end
        n_cmp++; if (c16 !== 4'd12) begin n_bad++; $display("FAIL load16_noclamp got %0d want 12", c16); end
        n_cmp++; if (b10 !== 1'b0 || tc10 !== 1'b0) begin n_bad++; $display("FAIL load_flags got busy=%b tc=%b want 0 0", b10, tc10); end
        tick(); tick();
        n_cmp++; if (c10 !== 4'd9 || c16 !== 4'd12) begin n_bad++; $display("FAIL idle_nostep got c10=%0d c16=%0d want 9 12", c10, c16); end
        en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        // d10 sits at 9 going up: a step would wrap with tc, the load must win.
        load = 1'b1; load_val = 4'd5; en = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        $display("load in run: c16=%0d c10=%0d tc10=%b busy=%b", c16, c10, tc10, b10);
        n_cmp++; if (c10 !== 4'd5 || tc10 !== 1'b0) begin n_bad++; $display("FAIL load_over_step got c=%0d tc=%b want 5 0", c10, tc10); end
        n_cmp++; if (b10 !== 1'b1) begin n_bad++; $display("FAIL load_keeps_state got busy=%b want 1", b10); end
    endtask

    // start/stop priority, back-to-back start, reset aborting a run.
    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1;
        tick();
        n_cmp++; if (b16 !== 1'b0) begin n_bad++; $display("FAIL stop_wins_run got busy=%b want 0", b16); end
        tick();
        start = 1'b0; stop = 1'b0;
        $display("start+stop: busy=%b", b16);
        n_cmp++; if (b16 !== 1'b0) begin n_bad++; $display("FAIL stop_wins_idle got busy=%b want 0", b16); end
        load = 1'b1; load_val = 4'd0; up = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        en = 1'b1;
        // start held in RUN keeps RUN and does not block stepping.
        for (int i = 1; i <= 7; i++) begin
            tick();
            start = 1'b0;
        end
        $display("run to 7: c16=%0d busy=%b", c16, b16);
        n_cmp++; if (c16 !== 4'd7 || b16 !== 1'b1) begin n_bad++; $display("FAIL run_to_7 got c=%0d busy=%b want 7 1", c16, b16); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset mid-run: c16=%0d busy=%b tc=%b", c16, b16, tc16);
        n_cmp++; if (c16 !== 4'd0 || b16 !== 1'b0 || tc16 !== 1'b0) begin n_bad++; $display("FAIL reset_abort got c=%0d busy=%b tc=%b want 0 0 0", c16, b16, tc16); end
        tick();
        n_cmp++; if (c16 !== 4'd0) begin n_bad++; $display("FAIL post_reset_idle got %0d want 0", c16); end
        en = 1'b0;
    endtask

`ifdef NS_COUNTER_BOUNCE_EN
    task automatic test_bounce();
        logic [1:0] exp_c [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        logic       exp_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; load_val = 4'd0; up = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            $display("bounce step %0d: count=%0d tc=%b", i + 1, cb, tcb);
            n_cmp++; if (cb !== exp_c[i] || tcb !== exp_t[i]) begin n_bad++; $display("FAIL bounce step %0d got c=%0d tc=%b want %0d %b", i + 1, cb, tcb, exp_c[i], exp_t[i]); end
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; up = 1'b1;
        load = 1'b0; load_val = 4'd0;
        test_reset();
`ifdef NS_COUNTER_BOUNCE_EN
        test_bounce();
`else
        test_up_wrap();
        test_down_wrap();
`endif
        test_load_clamp();
        test_start_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
